// File: rtl/gcore_pkg.sv
// Shared definitions for the GCore sequencer: state encoding, bus widths and stage decode helpers.
package gcore_pkg;

  localparam int GCORE_ADDR_W = 8;
  localparam int GCORE_DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PC    = 3'd1,
    S_FETCH = 3'd2,
    S_MEM   = 3'd3,
    S_ALU   = 3'd4,
    S_ACC   = 3'd5,
    S_OUT   = 3'd6,
    S_LOAD  = 3'd7
  } gcore_state_e;

  // Bit order {out, acc, alu, mem, opram, pc}; IDLE and LOAD own no stage.
  function automatic logic [5:0] stage_onehot(input gcore_state_e st);
    case (st)
      S_PC:    return 6'b000001;
      S_FETCH: return 6'b000010;
      S_MEM:   return 6'b000100;
      S_ALU:   return 6'b001000;
      S_ACC:   return 6'b010000;
      S_OUT:   return 6'b100000;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic is_phase(input gcore_state_e st);
    return (stage_onehot(st) != 6'b000000);
  endfunction

endpackage

// File: rtl/gcore_dwell_cnt.sv
// Phase dwell down-counter: loaded on phase entry, flags the first and last cycle of the dwell.
module gcore_dwell_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             first_cycle,
  output logic             last_cycle
);

  logic [CNT_W-1:0] cnt_r;
  logic             first_r;

  // Count register; holds at zero once the dwell has expired.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= {CNT_W{1'b0}};
      first_r <= 1'b0;
    end else if (load) begin
      cnt_r   <= load_val;
      first_r <= 1'b1;
    end else begin
      cnt_r   <= (cnt_r != {CNT_W{1'b0}}) ? (cnt_r - {{(CNT_W-1){1'b0}}, 1'b1}) : cnt_r;
      first_r <= 1'b0;
    end
  end

  assign first_cycle = first_r;
  assign last_cycle  = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/gcore_seq_ctrl.sv
// GCore instruction sequencer: stage enables, run/step/halt control and opram loader arbitration.
// Optional breakpoint unit enabled by defining GCORE_SEQ_BREAKPOINT_EN.
module gcore_seq_ctrl
  import gcore_pkg::*;
#(
  parameter int PHASE_CYCLES = 1,
  parameter int INSTR_CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    step,
  input  logic                    halt_req,
  input  logic                    load_req,
  input  logic                    load_we,
  input  logic [GCORE_ADDR_W-1:0] load_addr,
  input  logic [GCORE_DATA_W-1:0] load_data,
  output logic                    pc_en,
  output logic                    opram_en,
  output logic                    mem_en,
  output logic                    alu_en,
  output logic                    acc_en,
  output logic                    out_en,
  output logic                    load_gnt,
  output logic                    opram_we,
  output logic [GCORE_ADDR_W-1:0] opram_waddr,
  output logic [GCORE_DATA_W-1:0] opram_wdata,
  output logic                    busy,
  output logic                    halted,
  output logic [INSTR_CNT_W-1:0]  instr_cnt
`ifdef GCORE_SEQ_BREAKPOINT_EN
  ,
  input  logic [GCORE_ADDR_W-1:0] pc_addr,
  input  logic [GCORE_ADDR_W-1:0] bp_addr,
  input  logic                    bp_valid,
  output logic                    bp_hit
`endif
);

  gcore_state_e state_r, state_s;
  logic one_shot_r, one_shot_s;
  logic halted_r, halted_s;
  logic resume_r, resume_s;
  logic run_q_r, run_rise_s;
  logic retire_s, bp_match_s;
  logic dwell_load_s, first_cycle_s, last_cycle_s;
  logic load_gnt_r, busy_r, opram_we_r;
  logic [GCORE_ADDR_W-1:0] waddr_r;
  logic [GCORE_DATA_W-1:0] wdata_r;
  logic [INSTR_CNT_W-1:0]  instr_cnt_r;

  assign run_rise_s   = run & ~run_q_r;
  assign dwell_load_s = is_phase(state_s) && (state_s != state_r);

  gcore_dwell_cnt #(.CNT_W(8)) u_dwell (
    .clk         (clk),
    .rst         (rst),
    .load        (dwell_load_s),
    .load_val    (8'(PHASE_CYCLES - 1)),
    .first_cycle (first_cycle_s),
    .last_cycle  (last_cycle_s)
  );

  // Next-state, halt/one-shot bookkeeping and retire decision.
  always_comb begin
    state_s    = state_r;
    one_shot_s = one_shot_r;
    resume_s   = resume_r;
    retire_s   = 1'b0;
    halted_s   = run_rise_s ? 1'b0 : halted_r;
    case (state_r)
      S_IDLE: begin
        if (load_req) begin
          state_s = S_LOAD;
        end else if (run && !halted_s) begin
          state_s    = resume_r ? S_FETCH : S_PC;
          one_shot_s = 1'b0;
          resume_s   = 1'b0;
        end else if (step) begin
          state_s    = resume_r ? S_FETCH : S_PC;
          one_shot_s = 1'b1;
          resume_s   = 1'b0;
          halted_s   = 1'b0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_PC: begin
        // Breakpoint parks before fetch; resume skips S_PC so pc is not advanced twice.
        if (bp_match_s) begin
          state_s    = S_IDLE;
          halted_s   = 1'b1;
          resume_s   = 1'b1;
          one_shot_s = 1'b0;
        end else if (last_cycle_s) begin
          state_s = S_FETCH;
        end else begin
          state_s = S_PC;
        end
      end
      S_FETCH: state_s = last_cycle_s ? S_MEM : S_FETCH;
      S_MEM:   state_s = last_cycle_s ? S_ALU : S_MEM;
      S_ALU:   state_s = last_cycle_s ? S_ACC : S_ALU;
      S_ACC:   state_s = last_cycle_s ? S_OUT : S_ACC;
      S_OUT: begin
        if (last_cycle_s) begin
          retire_s   = 1'b1;
          one_shot_s = 1'b0;
          if (halt_req) begin
            halted_s = 1'b1;
            state_s  = S_IDLE;
          end else if (load_req) begin
            state_s = S_LOAD;
          end else if (run && !one_shot_r) begin
            state_s = S_PC;
          end else begin
            state_s = S_IDLE;
          end
        end else begin
          state_s = S_OUT;
        end
      end
      S_LOAD:  state_s = load_req ? S_LOAD : S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Control state, counters and registered status/loader outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      one_shot_r  <= 1'b0;
      halted_r    <= 1'b0;
      resume_r    <= 1'b0;
      run_q_r     <= 1'b0;
      instr_cnt_r <= {INSTR_CNT_W{1'b0}};
      load_gnt_r  <= 1'b0;
      busy_r      <= 1'b0;
      opram_we_r  <= 1'b0;
      waddr_r     <= {GCORE_ADDR_W{1'b0}};
      wdata_r     <= {GCORE_DATA_W{1'b0}};
    end else begin
      state_r     <= state_s;
      one_shot_r  <= one_shot_s;
      halted_r    <= halted_s;
      resume_r    <= resume_s;
      run_q_r     <= run;
      instr_cnt_r <= retire_s ? (instr_cnt_r + {{(INSTR_CNT_W-1){1'b0}}, 1'b1}) : instr_cnt_r;
      load_gnt_r  <= (state_s == S_LOAD);
      busy_r      <= (state_s != S_IDLE);
      // A write presented as load_req falls is dropped with the grant.
      opram_we_r  <= load_gnt_r & load_req & load_we;
      waddr_r     <= (load_gnt_r & load_req & load_we) ? load_addr : {GCORE_ADDR_W{1'b0}};
      wdata_r     <= (load_gnt_r & load_req & load_we) ? load_data : {GCORE_DATA_W{1'b0}};
    end
  end

`ifdef GCORE_SEQ_BREAKPOINT_EN
  logic bp_hit_r;

  assign bp_match_s = (state_r == S_PC) && last_cycle_s && bp_valid && (pc_addr == bp_addr);

  // Single-cycle breakpoint indication.
  always_ff @(posedge clk) begin
    if (rst) begin
      bp_hit_r <= 1'b0;
    end else begin
      bp_hit_r <= bp_match_s;
    end
  end

  assign bp_hit = bp_hit_r;
`else
  assign bp_match_s = 1'b0;
`endif

  assign {out_en, acc_en, alu_en, mem_en, opram_en, pc_en} =
    stage_onehot(state_r) & {6{first_cycle_s}};
  assign load_gnt    = load_gnt_r;
  assign busy        = busy_r;
  assign halted      = halted_r;
  assign instr_cnt   = instr_cnt_r;
  assign opram_we    = opram_we_r;
  assign opram_waddr = waddr_r;
  assign opram_wdata = wdata_r;

endmodule

// File: tb/tb_gcore_seq_ctrl.sv
// Directed bench for gcore_seq_ctrl: one instance with PHASE_CYCLES=1, one with PHASE_CYCLES=3.
module tb_gcore_seq_ctrl;

  logic clk, rst;
  logic run1, step1, halt1, lreq1, lwe1;
  logic [7:0] laddr1, ldata1;
  logic run3, step3, zero1;
  logic [7:0] zero8;

  logic pc1, op1, mem1, alu1, acc1, out1, gnt1, we1, busy1, hlt1;
  logic [7:0] wa1, wd1;
  logic [15:0] cnt1;
  logic pc3, op3, mem3, alu3, acc3, out3, gnt3, we3, busy3, hlt3;
  logic [7:0] wa3, wd3;
  logic [15:0] cnt3;
  logic [5:0] en1, en3;

`ifdef GCORE_SEQ_BREAKPOINT_EN
  logic [7:0] pca1, bpa1;
  logic bpv1, bph1, bph3;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  assign en1 = {out1, acc1, alu1, mem1, op1, pc1};
  assign en3 = {out3, acc3, alu3, mem3, op3, pc3};

  gcore_seq_ctrl #(.PHASE_CYCLES(1), .INSTR_CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .run(run1), .step(step1), .halt_req(halt1),
    .load_req(lreq1), .load_we(lwe1), .load_addr(laddr1), .load_data(ldata1),
    .pc_en(pc1), .opram_en(op1), .mem_en(mem1), .alu_en(alu1), .acc_en(acc1), .out_en(out1),
    .load_gnt(gnt1), .opram_we(we1), .opram_waddr(wa1), .opram_wdata(wd1),
    .busy(busy1), .halted(hlt1), .instr_cnt(cnt1)
`ifdef GCORE_SEQ_BREAKPOINT_EN
    , .pc_addr(pca1), .bp_addr(bpa1), .bp_valid(bpv1), .bp_hit(bph1)
`endif
  );

  gcore_seq_ctrl #(.PHASE_CYCLES(3), .INSTR_CNT_W(16)) dut3 (
    .clk(clk), .rst(rst), .run(run3), .step(step3), .halt_req(zero1),
    .load_req(zero1), .load_we(zero1), .load_addr(zero8), .load_data(zero8),
    .pc_en(pc3), .opram_en(op3), .mem_en(mem3), .alu_en(alu3), .acc_en(acc3), .out_en(out3),
    .load_gnt(gnt3), .opram_we(we3), .opram_waddr(wa3), .opram_wdata(wd3),
    .busy(busy3), .halted(hlt3), .instr_cnt(cnt3)
`ifdef GCORE_SEQ_BREAKPOINT_EN
    , .pc_addr(zero8), .bp_addr(zero8), .bp_valid(zero1), .bp_hit(bph3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [5:0] exp_en;
    rst = 1'b1; run1 = 1'b0; step1 = 1'b0; halt1 = 1'b0; lreq1 = 1'b0; lwe1 = 1'b0;
    laddr1 = 8'h00; ldata1 = 8'h00; run3 = 1'b0; step3 = 1'b0; zero1 = 1'b0; zero8 = 8'h00;
`ifdef GCORE_SEQ_BREAKPOINT_EN
    pca1 = 8'h00; bpa1 = 8'h10; bpv1 = 1'b0;
`endif
    cyc(); cyc();
    chk("rst_en1", {26'd0, en1}, 32'd0);
    chk("rst_busy1", {31'd0, busy1}, 32'd0);
    chk("rst_halted1", {31'd0, hlt1}, 32'd0);
    chk("rst_cnt1", {16'd0, cnt1}, 32'd0);
    chk("rst_gnt_we1", {30'd0, gnt1, we1}, 32'd0);
    chk("rst_wa_wd1", {16'd0, wa1, wd1}, 32'd0);
    chk("rst_all3", {6'd0, en3, busy3, hlt3, gnt3, we3, wa3, wd3}, 32'd0);
    chk("rst_cnt3", {16'd0, cnt3}, 32'd0);
`ifdef GCORE_SEQ_BREAKPOINT_EN
    chk("rst_bp", {30'd0, bph1, bph3}, 32'd0);
`endif

    // Free run, one cycle per phase
    rst = 1'b0; run1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      exp_en = 6'd1 << k;
      chk("run_en", {26'd0, en1}, {26'd0, exp_en});
    end
    chk("run_cnt_at_out", {16'd0, cnt1}, 32'd0);
    cyc();
    chk("run_repeat_pc", {26'd0, en1}, 32'd1);
    chk("run_cnt1", {16'd0, cnt1}, 32'd1);
    chk("run_busy", {31'd0, busy1}, 32'd1);

    // Drop run mid-instruction: it completes, then idles
    run1 = 1'b0;
    for (int k = 1; k < 6; k++) begin
      cyc();
      if (k == 2) step1 = 1'b1;
      else step1 = 1'b0;
      exp_en = 6'd1 << k;
      chk("stop_en", {26'd0, en1}, {26'd0, exp_en});
    end
    cyc();
    chk("stop_idle_en", {26'd0, en1}, 32'd0);
    chk("stop_idle_busy", {31'd0, busy1}, 32'd0);
    chk("stop_cnt", {16'd0, cnt1}, 32'd2);
    cyc();
    chk("step_busy_not_queued", {31'd0, busy1}, 32'd0);

    // Load request raised in S_ALU waits for the boundary
    run1 = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    chk("ld_alu", {26'd0, en1}, 32'h08);
    lreq1 = 1'b1;
    cyc(); cyc();
    chk("ld_out", {26'd0, en1}, 32'h20);
    chk("ld_gnt_early", {31'd0, gnt1}, 32'd0);
    cyc();
    chk("ld_gnt", {31'd0, gnt1}, 32'd1);
    chk("ld_busy", {31'd0, busy1}, 32'd1);
    chk("ld_no_en", {26'd0, en1}, 32'd0);
    chk("ld_cnt", {16'd0, cnt1}, 32'd3);
    lwe1 = 1'b1; laddr1 = 8'h05; ldata1 = 8'hA3;
    cyc();
    chk("ld_write", {15'd0, we1, wa1, wd1}, 32'h105A3);
    lwe1 = 1'b0;
    cyc();
    chk("ld_we_low", {15'd0, we1, wa1, wd1}, 32'd0);
    lreq1 = 1'b0; lwe1 = 1'b1; laddr1 = 8'h77; ldata1 = 8'h66;
    cyc();
    chk("ld_exit_gnt", {31'd0, gnt1}, 32'd0);
    chk("ld_exit_we", {31'd0, we1}, 32'd0);
    lwe1 = 1'b0;
    cyc();
    chk("ld_resume_pc", {26'd0, en1}, 32'd1);

    // Halt at the boundary; held run does not restart, a run edge does
    cyc(); cyc(); cyc(); cyc(); cyc();
    chk("halt_out", {26'd0, en1}, 32'h20);
    halt1 = 1'b1;
    cyc();
    halt1 = 1'b0;
    chk("halt_flag", {31'd0, hlt1}, 32'd1);
    chk("halt_busy", {31'd0, busy1}, 32'd0);
    chk("halt_cnt", {16'd0, cnt1}, 32'd4);
    cyc(); cyc();
    chk("halt_hold", {25'd0, busy1, en1}, 32'd0);
    run1 = 1'b0;
    cyc();
    run1 = 1'b1;
    cyc();
    chk("halt_resume_pc", {26'd0, en1}, 32'd1);
    chk("halt_cleared", {31'd0, hlt1}, 32'd0);
    run1 = 1'b0;
    cyc(); cyc(); cyc(); cyc(); cyc(); cyc();
    chk("halt_final_cnt", {16'd0, cnt1}, 32'd5);
    chk("halt_final_busy", {31'd0, busy1}, 32'd0);

    // Reset during a granted write, then reset with step
    lreq1 = 1'b1;
    cyc();
    chk("rl_gnt", {31'd0, gnt1}, 32'd1);
    lwe1 = 1'b1; laddr1 = 8'h33; ldata1 = 8'h44; rst = 1'b1;
    cyc();
    chk("rl_outputs", {8'd0, en1, gnt1, we1, busy1, hlt1, wa1, wd1}, 32'd0);
    chk("rl_cnt", {16'd0, cnt1}, 32'd0);
    lreq1 = 1'b0; lwe1 = 1'b0; step1 = 1'b1;
    cyc();
    chk("rs_busy", {31'd0, busy1}, 32'd0);
    rst = 1'b0; step1 = 1'b0;
    cyc();
    chk("rs_step_ignored", {25'd0, busy1, en1}, 32'd0);

`ifdef GCORE_SEQ_BREAKPOINT_EN
    // Breakpoint at 0x10 parks before fetch; next step resumes at fetch
    pca1 = 8'h10; bpv1 = 1'b1; step1 = 1'b1;
    cyc();
    step1 = 1'b0;
    chk("bp_pc", {26'd0, en1}, 32'd1);
    cyc();
    chk("bp_hit", {31'd0, bph1}, 32'd1);
    chk("bp_no_fetch", {26'd0, en1}, 32'd0);
    chk("bp_halted", {30'd0, hlt1, busy1}, 32'd2);
    cyc();
    chk("bp_pulse", {31'd0, bph1}, 32'd0);
    step1 = 1'b1;
    cyc();
    step1 = 1'b0;
    chk("bp_fetch", {26'd0, en1}, 32'd2);
    chk("bp_unhalt", {31'd0, hlt1}, 32'd0);
    cyc(); cyc(); cyc(); cyc(); cyc();
    chk("bp_retired", {16'd0, cnt1}, 32'd1);
    chk("bp_idle", {31'd0, busy1}, 32'd0);
    bpv1 = 1'b0;
`endif

    // Single step with three-cycle phases
    step3 = 1'b1;
    for (int i = 0; i < 18; i++) begin
      cyc();
      step3 = 1'b0;
      exp_en = ((i % 3) == 0) ? (6'd1 << (i / 3)) : 6'd0;
      chk("p3_en", {26'd0, en3}, {26'd0, exp_en});
      chk("p3_busy", {31'd0, busy3}, 32'd1);
    end
    cyc();
    chk("p3_idle", {25'd0, busy3, en3}, 32'd0);
    chk("p3_cnt", {16'd0, cnt3}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gcore_seq_ctrl.md
Name: gcore_seq_ctrl

Overview:
- Single-clock instruction sequencer for the GCore accumulator CPU. Replaces per-unit phase clocks with one-cycle clock-enable pulses in the order pc → opram → mem → alu → acc → out.
- Adds run / single-step / halt control.
- Arbitrates the opram write port between the CPU (read-only fetch) and an external program loader, granting the loader only at instruction boundaries.

Parameters:
- PHASE_CYCLES, 1: cycles each phase state dwells; legal range 1..255.
- INSTR_CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- run  in  1  level; free-run while high
- step  in  1  one-cycle pulse; execute exactly one instruction from IDLE
- halt_req  in  1  decoded halt opcode; sampled in S_OUT
- load_req  in  1  level; loader requests opram
- load_we  in  1  loader write strobe, valid while load_gnt
- load_addr  in  8  loader write address
- load_data  in  8  loader write data
- pc_en, opram_en, mem_en, alu_en, acc_en, out_en  out  1 each  one-cycle stage enables
- load_gnt  out  1  loader owns opram
- opram_we  out  1  registered opram write strobe
- opram_waddr  out  8  registered write address
- opram_wdata  out  8  registered write data
- busy  out  1  high in any state except S_IDLE
- halted  out  1  sticky; set by halt_req, cleared by rising run or by step
- instr_cnt  out  INSTR_CNT_W  retired instructions; wraps at 2^INSTR_CNT_W

Behaviour:
- Reset: all outputs 0; state S_IDLE; dwell counter 0; halted 0; instr_cnt 0.
- States: S_IDLE, S_PC, S_FETCH, S_MEM, S_ALU, S_ACC, S_OUT, S_LOAD.

Phase timing:
- Each phase state lasts PHASE_CYCLES cycles.
- Its enable is high on the first cycle of the dwell only. Mapping: S_PC→pc_en, S_FETCH→opram_en, S_MEM→mem_en, S_ALU→alu_en, S_ACC→acc_en, S_OUT→out_en.
- At most one enable is high in any cycle.
- Instruction latency: 6*PHASE_CYCLES cycles from leaving S_IDLE to re-entering the boundary decision.

S_IDLE exit priority:
1. load_req → S_LOAD
2. run & !halted → S_PC
3. step → S_PC, one-shot
4. otherwise stay in S_IDLE

End of S_OUT (instruction boundary):
- instr_cnt increments.
- If halt_req: halted←1, go to S_IDLE.
- Else if load_req: go to S_LOAD.
- Else if run & !one-shot: go to S_PC.
- Else: go to S_IDLE.

Control edge cases:
- run deasserted mid-instruction: the instruction completes, then S_IDLE.
- step while busy: ignored, not queued.
- step while halted: clears halted and executes one instruction.

S_LOAD:
- load_gnt=1.
- opram_we/waddr/wdata register load_we/addr/data with 1-cycle latency.
- Exit when load_req falls: load_gnt drops the same cycle, opram_we is 0 the next cycle, return to S_IDLE.
- No stage enables fire in S_LOAD.

Reset mid-operation:
- rst dominates everything.
- A write in flight is dropped: opram_we=0 on the cycle after rst is sampled.

Optional Feature:
- Macro: GCORE_SEQ_BREAKPOINT_EN.
- With it: extra input ports pc_addr[7:0], bp_addr[7:0], bp_valid, and output bp_hit.
- Comparison point: at the end of S_PC, pc_addr is compared against bp_addr.
- On a match with bp_valid=1: halted←1, bp_hit pulses for 1 cycle, go to S_IDLE before opram_en fires. The instruction is not counted.
- The next step or rising run resumes from S_FETCH with the same address, so the breakpoint does not immediately re-trigger.
- Without the macro: the ports are absent and behaviour is exactly as above.

Decomposition:
- Shared package gcore_pkg holds:
  - state encoding constants (3-bit, S_IDLE=0 … S_LOAD=7);
  - GCORE_ADDR_W=8 and GCORE_DATA_W=8.
- Sub-module gcore_dwell_cnt: loadable down-counter producing first_cycle and last_cycle for the phase dwell.
- FSM, loader register stage and instr_cnt stay in gcore_seq_ctrl.

Test Plan:
- Reset, then run=1 with PHASE_CYCLES=1 → enables appear pc,opram,mem,alu,acc,out on consecutive cycles 1..6. Repeats from cycle 7. instr_cnt=1 after cycle 6.
- PHASE_CYCLES=3, step pulse in IDLE → each enable high for 1 of 3 dwell cycles; busy high for 18 cycles; exactly one instruction retires; back to IDLE.
- run=1, assert load_req mid-S_ALU → current instruction finishes. load_gnt rises the cycle after S_OUT ends. Write of addr 0x05 / data 0xA3 appears on opram_we/waddr/wdata one cycle later.
- halt_req=1 during S_OUT → halted=1, IDLE, instr_cnt incremented. run held high does not restart. Toggling run 0→1 resumes.
- rst asserted during S_LOAD with load_we=1 → next cycle all outputs 0 and state IDLE. rst together with step → step ignored.
- (GCORE_SEQ_BREAKPOINT_EN) bp_addr=0x10, bp_valid=1, pc_addr reaches 0x10 → bp_hit pulse, no opram_en. The next step fetches 0x10 and retires it.
